// File: rtl/inv_mixcolumn.sv
// ----------------------------------------------------------------------------
// inv_mixcolumn
//
// Iterative AES InvMixColumns unit for the decrypt datapath. One 128-bit
// state is accepted through a valid/ready handshake. It is then transformed
// one column per cycle through a single shared column datapath. The result
// is held in a registered output until the downstream stage takes it.
//
// Byte layouts are chosen so that inv_mixcolumn(mixcolumn(x)) == x:
//   data_i : byte (row r, col c) at data_i[32c+8r +: 8]  (column-major)
//   data_o : byte (row r, col c) at data_o[32r+8c +: 8]  (row-major)
//
// Ports:
//   clk_i    - clock; all state updates on the rising edge
//   rst_ni   - asynchronous active-low reset
//   valid_i  - data_i holds a state to transform
//   ready_o  - block can accept a state (high only when idle)
//   data_i   - input state
//   valid_o  - data_o holds a completed result (registered)
//   ready_i  - downstream accepts data_o
//   data_o   - result state (registered)
// ----------------------------------------------------------------------------
module inv_mixcolumn (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         valid_i,
    output logic         ready_o,
    input  logic [127:0] data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [127:0] data_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [1:0]     r_cnt;
    logic [127:0]   r_work;
    logic [127:0]   r_data_o;
    logic           r_valid;
    logic [31:0]    w_col;
    logic [31:0]    w_col_res;

    // GF(2^8) multiply by x, reduction polynomial x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // The four InvMixColumns coefficients share one chain of three xtimes:
    // 09 = 8+1, 0b = 8+2+1, 0d = 8+4+1, 0e = 8+4+2.
    function automatic logic [31:0] inv_col(input logic [31:0] c);
        logic [7:0] a   [4];
        logic [7:0] x2  [4];
        logic [7:0] x4  [4];
        logic [7:0] x8  [4];
        logic [7:0] m09 [4];
        logic [7:0] m0b [4];
        logic [7:0] m0d [4];
        logic [7:0] m0e [4];
        logic [31:0] res;
        for (int r = 0; r < 4; r++) begin
            a[r]   = c[8*r +: 8];
            x2[r]  = xtime(a[r]);
            x4[r]  = xtime(x2[r]);
            x8[r]  = xtime(x4[r]);
            m09[r] = x8[r] ^ a[r];
            m0b[r] = x8[r] ^ x2[r] ^ a[r];
            m0d[r] = x8[r] ^ x4[r] ^ a[r];
            m0e[r] = x8[r] ^ x4[r] ^ x2[r];
        end
        res = '0;
        for (int r = 0; r < 4; r++) begin
            res[8*r +: 8] = m0e[r] ^ m0b[(r+1)%4] ^ m0d[(r+2)%4] ^ m09[(r+3)%4];
        end
        inv_col = res;
    endfunction

    // Column select: data_i is column-major, so column c is one 32-bit word
    // with row 0 in the low byte.
    always_comb begin
        w_col = '0;
        case (r_cnt)
            2'd0: w_col = r_work[31:0];
            2'd1: w_col = r_work[63:32];
            2'd2: w_col = r_work[95:64];
            2'd3: w_col = r_work[127:96];
            default: w_col = '0;
        endcase
    end

    always_comb begin
        w_col_res = inv_col(w_col);
    end

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; any unused encoding falls back to idle.
    always_comb begin
        w_state_nxt = S_IDLE;
        case (r_state)
            S_IDLE: w_state_nxt = valid_i ? S_CALC : S_IDLE;
            S_CALC: w_state_nxt = (r_cnt == 2'd3) ? S_DONE : S_CALC;
            S_DONE: w_state_nxt = ready_i ? S_IDLE : S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt    <= 2'd0;
            r_work   <= '0;
            r_data_o <= '0;
            r_valid  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (valid_i) begin
                        r_work <= data_i;
                        r_cnt  <= 2'd0;
                    end
                end
                S_CALC: begin
                    // Output is row-major: row r of column cnt lands at 32r+8cnt.
                    for (int r = 0; r < 4; r++) begin
                        r_data_o[32*r + 8*r_cnt +: 8] <= w_col_res[8*r +: 8];
                    end
                    r_cnt <= r_cnt + 2'd1;
                    if (r_cnt == 2'd3) begin
                        r_valid <= 1'b1;
                    end
                end
                S_DONE: begin
                    if (ready_i) begin
                        r_valid <= 1'b0;
                    end
                end
                default: begin
                    r_cnt   <= 2'd0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign ready_o = (r_state == S_IDLE);
    assign valid_o = r_valid;
    assign data_o  = r_data_o;

endmodule

// File: tb/tb_inv_mixcolumn.sv
// ----------------------------------------------------------------------------
// tb_inv_mixcolumn
//
// Bench for inv_mixcolumn. Known vectors live in a table. Random states are
// produced by running an independent forward MixColumns model on a random
// plaintext. Expected results are queued on input acceptance and compared
// when the DUT completes an output handshake.
// ----------------------------------------------------------------------------
module tb_inv_mixcolumn;

    logic         clk_i;
    logic         rst_ni;
    logic         valid_i;
    logic         ready_o;
    logic [127:0] data_i;
    logic         valid_o;
    logic         ready_i;
    logic [127:0] data_o;

    inv_mixcolumn dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_i  (data_i),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .data_o  (data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        string        name;
        logic [127:0] din;
        logic [127:0] exp;
    } vec_t;

    vec_t           tbl [5];
    logic [127:0]   sb_q [$];
    logic [127:0]   cur_exp;
    int             n_cmp;
    int             n_err;
    int             cyc;
    int             acc_cyc;
    bit             acc_pend;
    bit             prev_v;

    always @(posedge clk_i) cyc++;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", nm, got, exp);
        end
    endtask

    task automatic timeout(input string nm);
        n_cmp++;
        n_err++;
        $display("FAIL %s: timed out waiting on DUT", nm);
    endtask

    function automatic logic [7:0] xt(input logic [7:0] b);
        xt = (b << 1) ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Forward MixColumns: takes row-major state, returns column-major state.
    function automatic logic [127:0] fwd(input logic [127:0] s);
        logic [7:0]   a [4];
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = s[32*r + 8*c +: 8];
            for (int r = 0; r < 4; r++) begin
                o[32*c + 8*r +: 8] = xt(a[r]) ^ xt(a[(r+1)%4]) ^ a[(r+1)%4]
                                     ^ a[(r+2)%4] ^ a[(r+3)%4];
            end
        end
        return o;
    endfunction

    // Columns given as {row0,row1,row2,row3}, packed into the input layout.
    function automatic logic [127:0] in_cols(input logic [31:0] c0, input logic [31:0] c1,
                                             input logic [31:0] c2, input logic [31:0] c3);
        logic [31:0]  cc [4];
        logic [127:0] o;
        cc[0] = c0; cc[1] = c1; cc[2] = c2; cc[3] = c3;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[32*c + 8*r +: 8] = cc[c][31 - 8*r -: 8];
        return o;
    endfunction

    // Same column notation, packed into the output layout.
    function automatic logic [127:0] out_cols(input logic [31:0] c0, input logic [31:0] c1,
                                              input logic [31:0] c2, input logic [31:0] c3);
        logic [31:0]  cc [4];
        logic [127:0] o;
        cc[0] = c0; cc[1] = c1; cc[2] = c2; cc[3] = c3;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[32*r + 8*c +: 8] = cc[c][31 - 8*r -: 8];
        return o;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Scoreboard and latency monitor, sampled on the falling edge.
    always @(negedge clk_i) begin
        if (!rst_ni) begin
            sb_q.delete();
            acc_pend = 1'b0;
            prev_v   = 1'b0;
        end else begin
            if (valid_o && !prev_v && acc_pend) begin
                chk("latency", 128'(cyc - acc_cyc), 128'd4);
                acc_pend = 1'b0;
            end
            prev_v = valid_o;
            if (valid_o && ready_i) begin
                if (sb_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL sb_unexpected: got %h, expected no output", data_o);
                end else begin
                    chk("sb_data", data_o, sb_q.pop_front());
                end
            end
            if (valid_i && ready_o) begin
                sb_q.push_back(cur_exp);
                acc_pend = 1'b1;
                acc_cyc  = cyc + 1;
            end
        end
    end

    // Present a state and hold it until the edge that accepts it.
    task automatic send(input logic [127:0] d, input logic [127:0] e, output int ac);
        bit was_rdy;
        bit ok;
        valid_i = 1'b1;
        data_i  = d;
        cur_exp = e;
        ok      = 1'b0;
        ac      = 0;
        for (int n = 0; n < 40; n++) begin
            was_rdy = ready_o;
            @(posedge clk_i); #1;
            if (was_rdy) begin
                ok = 1'b1;
                ac = cyc;
                break;
            end
        end
        if (!ok) timeout("accept");
    endtask

    task automatic drain();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk_i); #1;
            if (sb_q.size() == 0 && ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("drain");
    endtask

    task automatic wait_valid();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (valid_o) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk_i); #1;
        end
        if (!ok) timeout("wait_valid");
    endtask

    task automatic reset_pulse();
        rst_ni = 1'b0;
        #1;
        chk("rst_valid_o", 128'(valid_o), 128'd0);
        chk("rst_data_o", data_o, 128'h0);
        chk("rst_ready_o", 128'(ready_o), 128'd1);
        sb_q.delete();
        acc_pend = 1'b0;
        #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;
    endtask

    initial begin
        int           ac;
        int           prev_ac;
        int           c0;
        logic [127:0] s;
        logic [127:0] sa;
        logic [127:0] sbv;
        logic [127:0] snap;

        n_cmp    = 0;
        n_err    = 0;
        cyc      = 0;
        acc_pend = 1'b0;
        prev_v   = 1'b0;
        rst_ni   = 1'b0;
        valid_i  = 1'b0;
        ready_i  = 1'b1;
        data_i   = '0;
        cur_exp  = '0;

        tbl[0] = '{"fips197",
                   in_cols(32'h8e4da1bc, 32'h9fdc589d, 32'h4d7ebdf8, 32'hd5d5d7d6),
                   out_cols(32'hdb135345, 32'hf20a225c, 32'h2d26314c, 32'hd4d4d4d5)};
        tbl[1] = '{"all_01", {16{8'h01}}, {16{8'h01}}};
        tbl[2] = '{"all_c6", {16{8'hc6}}, {16{8'hc6}}};
        tbl[3] = '{"all_00", 128'h0, 128'h0};
        tbl[4] = '{"mixed",
                   fwd(128'h00112233_44556677_8899aabb_ccddeeff),
                   128'h00112233_44556677_8899aabb_ccddeeff};

        repeat (2) @(posedge clk_i);
        #1;
        chk("init_ready_o", 128'(ready_o), 128'd1);
        chk("init_valid_o", 128'(valid_o), 128'd0);
        chk("init_data_o", data_o, 128'h0);
        rst_ni = 1'b1;

        // Known vectors
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].din, tbl[i].exp, ac);
            valid_i = 1'b0;
            drain();
            chk(tbl[i].name, data_o, tbl[i].exp);
        end

        // Round trip through the forward model
        for (int i = 0; i < 1000; i++) begin
            s = rand128();
            send(fwd(s), s, ac);
            valid_i = 1'b0;
            drain();
        end

        // Backpressure with a competing input held valid
        sa  = rand128();
        sbv = rand128();
        ready_i = 1'b0;
        send(fwd(sa), sa, ac);
        data_i  = fwd(sbv);
        cur_exp = sbv;
        wait_valid();
        snap = data_o;
        chk("bp_result", data_o, sa);
        for (int n = 0; n < 10; n++) begin
            @(posedge clk_i); #1;
            chk("bp_stable", data_o, snap);
            chk("bp_ready_o", 128'(ready_o), 128'd0);
            chk("bp_valid_o", 128'(valid_o), 128'd1);
        end
        ready_i = 1'b1;
        c0 = cyc;
        send(fwd(sbv), sbv, ac);
        chk("bp_accept_cycle", 128'(ac - c0), 128'd2);
        valid_i = 1'b0;
        drain();

        // Reset during CALC with cnt == 2
        s = rand128();
        send(fwd(s), s, ac);
        valid_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_pulse();
        s = rand128();
        send(fwd(s), s, ac);
        valid_i = 1'b0;
        drain();
        chk("post_rst_calc", data_o, s);

        // Reset while holding a result
        ready_i = 1'b0;
        s = rand128();
        send(fwd(s), s, ac);
        valid_i = 1'b0;
        wait_valid();
        reset_pulse();
        ready_i = 1'b1;
        s = rand128();
        send(fwd(s), s, ac);
        valid_i = 1'b0;
        drain();
        chk("post_rst_done", data_o, s);

        // Back-to-back stream, valid_i and ready_i held high
        prev_ac = 0;
        for (int k = 0; k < 5; k++) begin
            s = rand128();
            send(fwd(s), s, ac);
            if (k > 0) chk("b2b_spacing", 128'(ac - prev_ac), 128'd6);
            prev_ac = ac;
        end
        valid_i = 1'b0;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
